// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the baud-tick divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on pop_data while
// not empty; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO,
// plus sticky overrun / framing-error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  input  logic                        rd_en,
  input  logic                        err_clr,
  output logic                        rx_valid,
  output logic [7:0]                  rd_data,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        overrun,
  output logic                        frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  rx_state_e   state_q;
  logic [1:0]  sync_q;
  logic [DW-1:0] div_cnt_q;
  logic [3:0]  sample_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        push_q;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  logic        rxs, tick, stop_bad, ovf_evt;
  logic        fifo_full, fifo_empty;

  assign rxs  = sync_q[1];
  assign tick = (div_cnt_q == DIV_LAST);

  // Receiver: two-flop synchroniser, tick divider and frame FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      push_q       <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      push_q    <= 1'b0;
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_q      <= ST_START;
            sample_cnt_q <= '0;
            div_cnt_q    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sample_cnt_q == 4'(MID_SAMPLE)) begin
              sample_cnt_q <= '0;
              bit_idx_q    <= '0;
              state_q      <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              sample_cnt_q <= sample_cnt_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
            if (sample_cnt_q == 4'(LAST_SAMPLE)) begin
              shreg_q <= {rxs, shreg_q[7:1]};
              if (bit_idx_q == 3'd7) state_q <= ST_STOP;
              else                   bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
            if (sample_cnt_q == 4'(LAST_SAMPLE)) begin
              push_q  <= rxs;
              state_q <= rxs ? ST_IDLE : ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a break is not re-read as a start.
          if (rxs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stop_bad    = (state_q == ST_STOP) && tick &&
                  (sample_cnt_q == 4'(LAST_SAMPLE)) && !rxs;
    ovf_evt     = push_q && fifo_full && !(rd_en && rx_valid);
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (stop_bad) frame_err_d = 1'b1;
    if (ovf_evt)  overrun_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_valid  = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shreg_q),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued as frames are
// sent, and a monitor checks every popped byte against the queue head.
module tb_uart_rx_fifo;

  localparam int BIT_CYC    = 434;
  localparam int STOP_SHORT = 220;
  localparam int CW         = 5;

  logic          clk = 1'b0;
  logic          rst, rxd, rd_en, err_clr;
  logic          rx_valid;
  logic [7:0]    rd_data;
  logic [CW-1:0] rx_count;
  logic          overrun, frame_err;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            got;
  logic [7:0]    exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .rx_valid  (rx_valid),
    .rd_data   (rd_data),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cyc);
    rxd = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(BIT_CYC);
    end
    rxd = stop;
    cyc(stop_cyc);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_en && rx_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no byte", rd_data);
      end else begin
        chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    cyc(3);
    rst = 1'b0;

    // Reset state and quiet line
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_count", int'(rx_count), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (rx_valid || rx_count != 0 || frame_err || overrun) got = 1;
    end
    chk("quiet_line", got, 0);

    // Single byte with latency bound
    exp_q.push_back(8'hA5);
    got = 0;
    fork
      send_frame(8'hA5, 1'b1, STOP_SHORT);
      begin
        for (int i = 0; i < (19 * BIT_CYC) / 2 + 4 && got == 0; i++) begin
          cyc(1);
          if (rx_valid) got = 1;
        end
      end
    join
    chk("a5_within_latency", got, 1);
    chk("a5_count", int'(rx_count), 1);
    chk("a5_head", int'(rd_data), 8'hA5);
    pop_one();
    chk("a5_valid_after_pop", int'(rx_valid), 0);
    chk("a5_count_after_pop", int'(rx_count), 0);

    // Bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0, BIT_CYC);
    cyc(2 * BIT_CYC);
    chk("break_frame_err", int'(frame_err), 1);
    chk("break_count", int'(rx_count), 0);
    chk("break_valid", int'(rx_valid), 0);
    rxd = 1'b1;
    cyc(10);
    chk("break_release_count", int'(rx_count), 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("frame_err_cleared", int'(frame_err), 0);

    // Short low glitch is rejected
    rxd = 1'b0;
    cyc(100);
    rxd = 1'b1;
    cyc(300);
    chk("glitch_count", int'(rx_count), 0);
    chk("glitch_frame_err", int'(frame_err), 0);

    // Fill past capacity
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, STOP_SHORT);
    end
    cyc(4);
    chk("full_count", int'(rx_count), 16);
    chk("full_overrun", int'(overrun), 1);
    chk("full_head", int'(rd_data), 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("overrun_cleared", int'(overrun), 0);

    // Push and pop in the same cycle while full
    exp_q.push_back(8'h11);
    fork
      send_frame(8'h11, 1'b1, STOP_SHORT);
      begin
        cyc(4107);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
      end
    join
    chk("full_pushpop_count", int'(rx_count), 16);
    chk("full_pushpop_overrun", int'(overrun), 0);
    for (int i = 0; i < 16; i++) pop_one();
    chk("drain_count", int'(rx_count), 0);
    chk("drain_valid", int'(rx_valid), 0);
    chk("drain_scoreboard_left", exp_q.size(), 0);

    // Reset in the middle of a frame, then a clean byte
    rxd = 1'b0;
    cyc(3 * BIT_CYC);
    rst = 1'b1;
    rxd = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("midrst_count", int'(rx_count), 0);
    cyc(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, STOP_SHORT);
    cyc(4);
    chk("midrst_5a_count", int'(rx_count), 1);
    chk("midrst_frame_err", int'(frame_err), 0);
    chk("midrst_overrun", int'(overrun), 0);
    pop_one();
    chk("midrst_scoreboard_left", exp_q.size(), 0);
    chk("midrst_final_count", int'(rx_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
